// File: rtl/cordic_angle_sequencer.sv
// Front end of the Cordic sin/cos pipeline: emits a burst of N equally spaced phase angles
// and a sample strobe realigned to the Cordic output so capture logic needs no latency knowledge.
module cordic_angle_sequencer #(
    parameter int              BW      = 32,
    parameter int              NW      = 16,
    parameter int              LATENCY = 32,
    parameter logic [BW-1:0]   XGAIN   = 32'h4DBA76D4
) (
    input  logic          master_clk,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] num_points,
    input  logic          pause,
    output logic [31:0]   angle,
    output logic [BW-1:0] Xin,
    output logic [BW-1:0] Yin,
    output logic          angle_valid,
    output logic          sample_valid,
    output logic [NW-1:0] sample_index,
    output logic          busy,
    output logic          done,
    output logic          error
);

    // state | meaning
    // IDLE  | waiting for start
    // DIV   | restoring divide, q = floor(2^32/N), r = 2^32 mod N
    // RUN   | one angle per unpaused cycle
    // DRAIN | last sample still inside the Cordic pipeline
    typedef enum logic [1:0] {IDLE, DIV, RUN, DRAIN} state_t;

    localparam int TMAX = (LATENCY > 32) ? LATENCY : 32;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, state_next;
    logic          accept, emit, last;
    logic [TW-1:0] tmr;
    logic [NW-1:0] n_reg, rem, err, idx, cur_idx;
    logic [31:0]   q, acc, acc_nx;
    logic [NW:0]   rem_sh, err_sum;
    logic [NW-1:0] rem_sub, err_sub;
    logic          dbit, rem_ge, err_wrap;

    logic [LATENCY-1:0] valid_dly;
    logic [NW-1:0]      idx_dly [LATENCY];

    assign Xin          = XGAIN;
    assign Yin          = '0;
    assign busy         = (state != IDLE);
    assign sample_valid = valid_dly[LATENCY-1];
    assign sample_index = idx_dly[LATENCY-1];

    // Dividend 2^32 is a single 1 followed by 32 zeros, fed MSB first while tmr counts 32..0.
    assign dbit    = (tmr == TW'(32));
    assign rem_sh  = {rem, dbit};
    assign rem_ge  = (rem_sh >= {1'b0, n_reg});
    assign rem_sub = rem_sh[NW-1:0] - n_reg;

    assign err_sum  = {1'b0, err} + {1'b0, rem};
    assign err_wrap = (err_sum >= {1'b0, n_reg});
    assign err_sub  = err_sum[NW-1:0] - n_reg;
    assign acc_nx   = acc + q + {31'b0, err_wrap};

    always_ff @(posedge master_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        emit       = 1'b0;
        last       = (idx == (n_reg - NW'(1)));
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (num_points == '0) begin
                        state_next = IDLE;
                    end else if (num_points == NW'(1)) begin
                        state_next = RUN;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            DIV: begin
                if (tmr == '0) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!pause) begin
                    emit = 1'b1;
                    if (last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tmr == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            n_reg       <= '0;
            rem         <= '0;
            err         <= '0;
            idx         <= '0;
            cur_idx     <= '0;
            q           <= '0;
            acc         <= '0;
            tmr         <= '0;
            angle       <= '0;
            angle_valid <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            angle_valid <= 1'b0;
            done        <= 1'b0;
            if (tmr != '0) begin
                tmr <= tmr - TW'(1);
            end
            if (accept) begin
                n_reg <= num_points;
                error <= (num_points == '0);
                done  <= (num_points == '0);
                tmr   <= TW'(32);
                rem   <= '0;
                q     <= '0;
                acc   <= '0;
                err   <= '0;
                idx   <= '0;
            end
            if (state == DIV) begin
                rem <= rem_ge ? rem_sub : rem_sh[NW-1:0];
                q   <= {q[30:0], rem_ge};
            end
            if (emit) begin
                angle       <= acc;
                angle_valid <= 1'b1;
                cur_idx     <= idx;
                acc         <= acc_nx;
                err         <= err_wrap ? err_sub : err_sum[NW-1:0];
                idx         <= idx + NW'(1);
                if (last) begin
                    tmr <= TW'(LATENCY);
                end
            end
            if (state == DRAIN && tmr == '0) begin
                done <= 1'b1;
            end
        end
    end

    // Free-running match of the Cordic pipeline depth; keeps shifting through pause.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            valid_dly <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                idx_dly[k] <= '0;
            end
        end else begin
            valid_dly  <= {valid_dly[LATENCY-2:0], angle_valid};
            idx_dly[0] <= cur_idx;
            for (int k = 1; k < LATENCY; k++) begin
                idx_dly[k] <= idx_dly[k-1];
            end
        end
    end

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Directed bench for cordic_angle_sequencer: burst angles, timing, pause, reset abort, N edge cases.
module tb_cordic_angle_sequencer;

    localparam int LAT = 32;

    logic        master_clk = 1'b0;
    logic        reset, start, pause;
    logic [15:0] num_points;
    logic [31:0] angle, Xin, Yin;
    logic        angle_valid, sample_valid, busy, done, error;
    logic [15:0] sample_index;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          av_cyc[$];
    logic [31:0] av_ang[$];
    int          sv_cyc[$];
    logic [15:0] sv_idx[$];
    int          done_cyc[$];

    logic [31:0] exp4 [4] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    logic [31:0] exp3 [3] = '{32'h0000_0000, 32'h5555_5555, 32'hAAAA_AAAA};

    cordic_angle_sequencer dut (
        .master_clk   (master_clk),
        .reset        (reset),
        .start        (start),
        .num_points   (num_points),
        .pause        (pause),
        .angle        (angle),
        .Xin          (Xin),
        .Yin          (Yin),
        .angle_valid  (angle_valid),
        .sample_valid (sample_valid),
        .sample_index (sample_index),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 master_clk = ~master_clk;

    // Event log stamped with the number of the rising edge that produced it.
    always @(posedge master_clk) begin
        cyc++;
        #2;
        if (angle_valid) begin
            av_cyc.push_back(cyc);
            av_ang.push_back(angle);
        end
        if (sample_valid) begin
            sv_cyc.push_back(cyc);
            sv_idx.push_back(sample_index);
        end
        if (done) done_cyc.push_back(cyc);
    end

    task automatic clear_log();
        av_cyc.delete();
        av_ang.delete();
        sv_cyc.delete();
        sv_idx.delete();
        done_cyc.delete();
    endtask

    task automatic start_burst(input int n, output int t);
        @(negedge master_clk);
        start      = 1'b1;
        num_points = n[15:0];
        t          = cyc + 1;
        @(negedge master_clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_cyc.size() == 0 && k < budget) begin
            @(negedge master_clk);
            k++;
        end
        checks++;
        if (done_cyc.size() == 0) begin
            errors++;
            $display("FAIL %s_timeout: got no done, required done within %0d cycles", name, budget);
        end
        repeat (4) @(negedge master_clk);
    endtask

    task automatic test_reset();
        logic [31:0] act [9];
        logic [31:0] req [9];
        reset = 1'b1; start = 1'b0; pause = 1'b0; num_points = '0;
        repeat (3) @(negedge master_clk);
        act = '{angle, Xin, Yin, 32'(angle_valid), 32'(sample_valid), 32'(sample_index),
                32'(busy), 32'(done), 32'(error)};
        req = '{32'h0, 32'h4DBA_76D4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (act[i] !== req[i]) begin
                errors++;
                $display("FAIL reset_out%0d: got %h required %h", i, act[i], req[i]);
            end
        end
        reset = 1'b0;
        @(negedge master_clk);
    endtask

    task automatic test_n4(input string name);
        int t;
        clear_log();
        start_burst(4, t);
        wait_done(200, name);
        checks++;
        if (av_ang.size() != 4 || sv_idx.size() != 4) begin
            errors++;
            $display("FAIL %s_count: got %0d angles %0d samples, required 4 and 4",
                     name, av_ang.size(), sv_idx.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < av_ang.size()) begin
                checks++;
                if (av_ang[i] !== exp4[i] || av_cyc[i] != t + 34 + i) begin
                    errors++;
                    $display("FAIL %s_angle%0d: got %h at edge %0d, required %h at edge %0d",
                             name, i, av_ang[i], av_cyc[i], exp4[i], t + 34 + i);
                end
            end
            if (i < sv_idx.size()) begin
                checks++;
                if (sv_idx[i] !== 16'(i) || sv_cyc[i] != t + 34 + i + LAT) begin
                    errors++;
                    $display("FAIL %s_sample%0d: got index %0d at edge %0d, required %0d at edge %0d",
                             name, i, sv_idx[i], sv_cyc[i], i, t + 34 + i + LAT);
                end
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != t + 37 + LAT + 1) begin
            errors++;
            $display("FAIL %s_done: got %0d pulses first at edge %0d, required 1 at edge %0d",
                     name, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 37 + LAT + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after: got %b required 0", name, busy);
        end
    endtask

    task automatic test_n360();
        int t, bad_ang, bad_smp;
        logic [63:0] num;
        logic [31:0] expa;
        clear_log();
        start_burst(360, t);
        wait_done(1500, "n360");
        checks++;
        if (av_ang.size() != 360 || sv_idx.size() != 360) begin
            errors++;
            $display("FAIL n360_count: got %0d angles %0d samples, required 360 and 360",
                     av_ang.size(), sv_idx.size());
        end
        if (av_ang.size() == 360) begin
            checks++;
            if (av_ang[1] !== 32'h00B6_0B60) begin
                errors++;
                $display("FAIL n360_angle1: got %h required 00b60b60", av_ang[1]);
            end
            checks++;
            if (av_ang[90] !== 32'h4000_0000) begin
                errors++;
                $display("FAIL n360_angle90: got %h required 40000000", av_ang[90]);
            end
            checks++;
            if (av_ang[359] !== 32'hFF49_F49F) begin
                errors++;
                $display("FAIL n360_angle359: got %h required ff49f49f", av_ang[359]);
            end
        end
        bad_ang = 0;
        for (int i = 0; i < av_ang.size(); i++) begin
            num  = 64'(i) << 32;
            expa = 32'(num / 64'd360);
            if (av_ang[i] !== expa || av_cyc[i] != av_cyc[0] + i) bad_ang++;
        end
        checks++;
        if (bad_ang != 0) begin
            errors++;
            $display("FAIL n360_all_angles: got %0d wrong or non-consecutive, required 0", bad_ang);
        end
        bad_smp = 0;
        for (int i = 0; i < sv_idx.size(); i++) begin
            if (sv_idx[i] !== 16'(i) || i >= av_cyc.size() || sv_cyc[i] != av_cyc[i] + LAT) bad_smp++;
        end
        checks++;
        if (bad_smp != 0) begin
            errors++;
            $display("FAIL n360_samples: got %0d out-of-order or mistimed, required 0", bad_smp);
        end
    endtask

    task automatic test_pause();
        int t, k;
        clear_log();
        start_burst(3, t);
        k = 0;
        while (av_ang.size() < 2 && k < 100) begin
            @(negedge master_clk);
            k++;
        end
        checks++;
        if (av_ang.size() < 2) begin
            errors++;
            $display("FAIL pause_reach_i1: got %0d angles, required 2 within 100 cycles", av_ang.size());
        end
        pause = 1'b1;
        repeat (3) @(negedge master_clk);
        checks++;
        if (angle !== 32'h5555_5555 || angle_valid !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold: got angle %h valid %b, required 55555555 valid 0", angle, angle_valid);
        end
        repeat (2) @(negedge master_clk);
        pause = 1'b0;
        wait_done(200, "pause");
        checks++;
        if (av_ang.size() != 3 || sv_idx.size() != 3) begin
            errors++;
            $display("FAIL pause_count: got %0d angles %0d samples, required 3 and 3",
                     av_ang.size(), sv_idx.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (av_ang[i] !== exp3[i] || sv_idx[i] !== 16'(i) || sv_cyc[i] != av_cyc[i] + LAT) begin
                    errors++;
                    $display("FAIL pause_sample%0d: got angle %h index %0d delay %0d, required %h %0d %0d",
                             i, av_ang[i], sv_idx[i], sv_cyc[i] - av_cyc[i], exp3[i], i, LAT);
                end
            end
            checks++;
            if (av_cyc[1] != av_cyc[0] + 1 || av_cyc[2] != av_cyc[1] + 6) begin
                errors++;
                $display("FAIL pause_gap: got spacings %0d %0d, required 1 6",
                         av_cyc[1] - av_cyc[0], av_cyc[2] - av_cyc[1]);
            end
        end
    endtask

    task automatic test_n0();
        int t;
        clear_log();
        start_burst(0, t);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL n0_error: got error %b busy %b, required 1 0", error, busy);
        end
        repeat (6) @(negedge master_clk);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != t || av_ang.size() != 0) begin
            errors++;
            $display("FAIL n0_done: got %0d done first at %0d with %0d angles, required 1 at %0d with 0",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, av_ang.size(), t);
        end
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL n0_sticky: got error %b required 1", error);
        end
    endtask

    task automatic test_n1();
        int t;
        clear_log();
        start_burst(1, t);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL n1_error_clear: got %b required 0", error);
        end
        wait_done(200, "n1");
        checks++;
        if (av_ang.size() != 1 || sv_idx.size() != 1 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL n1_count: got %0d angles %0d samples %0d done, required 1 1 1",
                     av_ang.size(), sv_idx.size(), done_cyc.size());
        end else begin
            checks++;
            if (av_ang[0] !== 32'h0 || sv_idx[0] !== 16'h0 || sv_cyc[0] != av_cyc[0] + LAT) begin
                errors++;
                $display("FAIL n1_value: got angle %h index %0d delay %0d, required 0 0 %0d",
                         av_ang[0], sv_idx[0], sv_cyc[0] - av_cyc[0], LAT);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int t, k;
        logic [31:0] act [7];
        clear_log();
        start_burst(360, t);
        k = 0;
        while (av_ang.size() < 101 && k < 400) begin
            @(negedge master_clk);
            k++;
        end
        checks++;
        if (av_ang.size() < 101) begin
            errors++;
            $display("FAIL rstmid_reach_i100: got %0d angles, required 101 within 400 cycles", av_ang.size());
        end
        reset = 1'b1;
        @(negedge master_clk);
        act = '{angle, 32'(angle_valid), 32'(sample_valid), 32'(sample_index), 32'(busy),
                32'(done), 32'(error)};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (act[i] !== 32'h0) begin
                errors++;
                $display("FAIL rstmid_out%0d: got %h required 0", i, act[i]);
            end
        end
        reset = 1'b0;
        clear_log();
        repeat (60) @(negedge master_clk);
        checks++;
        if (done_cyc.size() != 0 || av_ang.size() != 0 || sv_idx.size() != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d done %0d angles %0d samples, required 0 0 0",
                     done_cyc.size(), av_ang.size(), sv_idx.size());
        end
        test_n4("n4_after_reset");
    endtask

    task automatic test_start_ignored();
        int t, k;
        clear_log();
        start_burst(4, t);
        repeat (10) @(negedge master_clk);
        start = 1'b1; num_points = 16'd7;
        @(negedge master_clk);
        start = 1'b0;
        k = 0;
        while (av_ang.size() < 1 && k < 100) begin
            @(negedge master_clk);
            k++;
        end
        start = 1'b1; num_points = 16'd2;
        @(negedge master_clk);
        start = 1'b0;
        wait_done(200, "ignored");
        repeat (40) @(negedge master_clk);
        checks++;
        if (av_ang.size() != 4 || done_cyc.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_count: got %0d angles %0d done busy %b, required 4 1 0",
                     av_ang.size(), done_cyc.size(), busy);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (av_ang[i] !== exp4[i] || av_cyc[i] != t + 34 + i) begin
                    errors++;
                    $display("FAIL ignored_angle%0d: got %h at edge %0d, required %h at edge %0d",
                             i, av_ang[i], av_cyc[i], exp4[i], t + 34 + i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_n4("n4");
        test_n360();
        test_pause();
        test_n0();
        test_n1();
        test_reset_mid_run();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
